button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Conditions the raw board push-button pins before they reach the SoC button input.
//  Per button: 2-FF synchroniser, then a debounce counter. Outputs are a clean level
//  plus one-cycle rise/fall pulses, all in the PLL clock domain.
//  Sits between the top-level `buttons` pins and the core's `buttons` port.
// PARAMETERS
//  BUTTONCOUNT      4       number of independent button channels
//  DEBOUNCE_CYCLES  240000  consecutive stable cycles required (10 ms @ 24 MHz); must be >= 2
//  ACTIVE_LOW       0       1: pin low = pressed; inverted at the synchroniser input
// PORTS
//  clk          in   1            PLL clock; the only clock
//  reset_n      in   1            asynchronous, active-low reset
//  buttons_in   in   BUTTONCOUNT  raw asynchronous pins
//  buttons_out  out  BUTTONCOUNT  debounced level, 1 = pressed
//  rise         out  BUTTONCOUNT  1-cycle pulse on debounced press
//  fall         out  BUTTONCOUNT  1-cycle pulse on debounced release
//  pending      out  BUTTONCOUNT  [BUTTON_IRQ_EN only] sticky press flags
//  pending_clr  in   BUTTONCOUNT  [BUTTON_IRQ_EN only] write-1-to-clear
//  irq          out  1            [BUTTON_IRQ_EN only] OR of pending
// BEHAVIOUR
//  - Reset (async assert, sync release by the parent): sync FFs, count, buttons_out, rise,
//    fall, pending and irq all 0 (released state). No pulse is emitted on reset exit.
//  - Sync: s1 <= pin ^ ACTIVE_LOW; s2 <= s1.
//  - Per channel, 2-state FSM:
//    STABLE: s2 == buttons_out, count = 0. On mismatch -> CHANGING, count <= 1.
//    CHANGING: mismatch and count < DEBOUNCE_CYCLES-1 -> count++.
//      mismatch and count == DEBOUNCE_CYCLES-1 -> buttons_out <= s2, count <= 0,
//      rise/fall <= 1 for one cycle, -> STABLE.
//      any single-cycle match -> count <= 0, -> STABLE, with no output change (glitch rejected).
//  - Latency: buttons_out and the pulse change at the (DEBOUNCE_CYCLES+1)th edge after
//    the edge where s1 first captures the new level.
//  - Counter width: $clog2(DEBOUNCE_CYCLES). It never wraps because the compare bounds it.
//  - rise and fall are mutually exclusive per channel. They are registered, not combinational.
//  - Channels are fully independent. Simultaneous presses give simultaneous pulses.
//  - Reset mid-count discards the partial count. The channel restarts from released.
// CONFIGURATION
//  Macro BUTTON_IRQ_EN:
//  - Defined: pending[i] is set by rise[i] and cleared by pending_clr[i].
//    Set wins over clear in the same cycle. irq = |pending, registered, so it is 1 cycle after set.
//  - Undefined: the pending, pending_clr and irq ports and their logic do not exist.
//    Port list and behaviour are otherwise identical.
// STRUCTURE
//  - Package button_pkg: DEBOUNCE_DEFAULT constant; typedef enum logic {STABLE, CHANGING} deb_state_t.
//  - Sub-module debounce_channel: one bit holding sync, counter, FSM and pulses.
//    The top generates BUTTONCOUNT instances. The pending/irq logic stays in the top.
// TESTING  (bench: DEBOUNCE_CYCLES=8, ACTIVE_LOW=0, BUTTONCOUNT=4)
//  1. Release reset with buttons_in=4'b0000 -> all outputs 0; no rise/fall for 20 cycles.
//  2. Raise buttons_in[0] and hold -> buttons_out[0]=1 and rise[0]=1 for exactly one
//     cycle, at edge 9 after the first sampling edge.
//  3. Toggle buttons_in[1] with a 3-cycle high, 1-cycle low bounce for 40 cycles
//     -> buttons_out[1] stays 0; no pulses.
//  4. Raise bits 2 and 3 on the same edge, hold, then drop bit 3 -> rise[2] and rise[3]
//     coincide; fall[3] comes 9 edges after the drop; bit 2 is unaffected.
//  5. Assert reset_n=0 with count at 5 mid-press, then release with the pin still high
//     -> outputs 0 immediately; a fresh 9-edge latency applies before rise.
//  6. [BUTTON_IRQ_EN] Press btn0 -> pending=4'b0001, irq=1 one cycle later.
//     pending_clr[0] in the same cycle as a new rise[0] -> pending[0] stays 1.
//     Clear alone -> irq=0 next cycle.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button debounce block.
package button_pkg;

  // 10 ms of stability at a 24 MHz PLL clock.
  localparam int unsigned DEBOUNCE_DEFAULT = 240000;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

  // Count width for a given debounce length; never narrower than one bit.
  function automatic int unsigned deb_count_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchroniser, run-length debounce FSM and
// registered one-cycle press/release pulses.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CW   = deb_count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          s1_q;
  logic          s2_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic          fall_q,  fall_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Polarity is folded in before the first flop so everything after sees 1 = pressed.
      s1_q    <= pin_i ^ ACTIVE_LOW;
      s2_q    <= s1_q;
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE: begin
        count_d = '0;
        if (s2_q != level_q) begin
          state_d = CHANGING;
          count_d = ONE;
        end
      end
      CHANGING: begin
        if (s2_q == level_q) begin
          // A single matching sample abandons the run: treated as bounce.
          state_d = STABLE;
          count_d = '0;
        end else if (count_q == LAST) begin
          state_d = STABLE;
          count_d = '0;
          level_d = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = STABLE;
        count_d = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces BUTTONCOUNT raw board buttons into clean levels and press/release pulses.
// Define BUTTON_IRQ_EN to add sticky pending flags (write-1-to-clear) and an irq output.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned BUTTONCOUNT     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  output logic [BUTTONCOUNT-1:0] buttons_out,
  output logic [BUTTONCOUNT-1:0] rise,
  output logic [BUTTONCOUNT-1:0] fall
`ifdef BUTTON_IRQ_EN
  ,
  output logic [BUTTONCOUNT-1:0] pending,
  input  logic [BUTTONCOUNT-1:0] pending_clr,
  output logic                   irq
`endif
);

  for (genvar gi = 0; gi < BUTTONCOUNT; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .pin_i   (buttons_in[gi]),
      .level_o (buttons_out[gi]),
      .rise_o  (rise[gi]),
      .fall_o  (fall[gi])
    );
  end

`ifdef BUTTON_IRQ_EN
  logic [BUTTONCOUNT-1:0] pending_q, pending_d;
  logic                   irq_q;

  // A press arriving in the same cycle as its clear must not be lost, so set wins.
  always_comb begin
    pending_d = (pending_q & ~pending_clr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign pending = pending_q;
  assign irq     = irq_q;
`endif

endmodule
